// File: rtl/chip_6502_pkg.sv
// Shared definitions for the 6502 bus sequencer: state encoding, idle data
// value and default timing parameters.
package chip_6502_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_RST     = 3'd0;
  localparam state_t S_PHI1    = 3'd1;
  localparam state_t S_RD_WAIT = 3'd2;
  localparam state_t S_PHI2    = 3'd3;
  localparam state_t S_WR_WAIT = 3'd4;

  localparam logic [7:0] DBI_IDLE = 8'hFF;

  localparam int HALF_CYCLES_DEF  = 16;
  localparam int RESET_CYCLES_DEF = 8;

endpackage

// File: rtl/chip_6502_phase_cnt.sv
// Wrapping counter 0..last with terminal-count output; used both for the
// phi half-phase settle count and for counting reset phi cycles.
module chip_6502_phase_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] last,
  output logic       tc
);

  logic [7:0] cnt_q, cnt_d;

  assign tc = (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = tc ? 8'd0 : cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/chip_6502_bus.sv
// Bus sequencer in front of the gate-level 6502: stretched phi generation,
// core reset, one req/ack memory transaction per bus cycle.
// Optional single-instruction stepping: define CHIP_6502_STEP_EN.
module chip_6502_bus
  import chip_6502_pkg::*;
#(
  parameter int HALF_CYCLES  = HALF_CYCLES_DEF,
  parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        phi,
  output logic        cpu_res,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dbo,
  output logic [7:0]  cpu_dbi,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
`ifdef CHIP_6502_STEP_EN
  input  logic        cpu_sync,
  input  logic        step_mode,
  input  logic        step,
  output logic        halted,
`endif
  output state_t      dbg_state
);

  localparam logic [7:0] HC_LAST = 8'(HALF_CYCLES - 1);
  localparam logic [7:0] RC_LAST = 8'(RESET_CYCLES - 1);

  state_t      state_q, state_d;
  logic        phi_q, phi_d;
  logic        cpu_res_q, cpu_res_d;
  logic [7:0]  cpu_dbi_q, cpu_dbi_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        hc_en, hc_tc, rc_en, rc_tc, hold;

`ifdef CHIP_6502_STEP_EN
  logic halted_q, halted_d, released_q, released_d;
  assign halted = halted_q;
`endif

  chip_6502_phase_cnt u_hc (
    .clk(clk), .rst(rst), .en(hc_en), .last(HC_LAST), .tc(hc_tc)
  );

  chip_6502_phase_cnt u_rc (
    .clk(clk), .rst(rst), .en(rc_en), .last(RC_LAST), .tc(rc_tc)
  );

  always_comb begin
    state_d     = state_q;
    phi_d       = phi_q;
    cpu_res_d   = cpu_res_q;
    cpu_dbi_d   = cpu_dbi_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hc_en       = 1'b1;
    rc_en       = 1'b0;
    hold        = 1'b0;
`ifdef CHIP_6502_STEP_EN
    halted_d    = halted_q;
    released_d  = released_q;
`endif
    case (state_q)
      S_RST: begin
        if (hc_tc) begin
          phi_d = !phi_q;
          // A falling phi edge closes one full reset phi cycle.
          if (phi_q) begin
            rc_en = 1'b1;
            if (rc_tc) begin
              cpu_res_d = 1'b1;
              state_d   = S_PHI1;
            end
          end
        end
      end
      S_PHI1: begin
`ifdef CHIP_6502_STEP_EN
        // Opcode fetch is held at the end of phi1 until a step releases it.
        if (halted_q) begin
          hold  = 1'b1;
          hc_en = 1'b0;
          if (step) begin
            halted_d   = 1'b0;
            released_d = 1'b1;
          end
        end else if (hc_tc && step_mode && cpu_sync && !released_q) begin
          hold     = 1'b1;
          hc_en    = 1'b0;
          halted_d = 1'b1;
        end
`endif
        if (!hold && hc_tc) begin
`ifdef CHIP_6502_STEP_EN
          released_d = 1'b0;
`endif
          mem_addr_d = cpu_ab;
          mem_we_d   = !cpu_rw;
          phi_d      = 1'b1;
          if (cpu_rw) begin
            mem_req_d = 1'b1;
            state_d   = S_RD_WAIT;
          end else begin
            state_d   = S_PHI2;
          end
        end
      end
      S_RD_WAIT: begin
        hc_en = 1'b0;
        if (mem_ack) begin
          cpu_dbi_d = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_PHI2;
        end
      end
      S_PHI2: begin
        if (hc_tc) begin
          if (mem_we_q) begin
            mem_wdata_d = cpu_dbo;
            mem_req_d   = 1'b1;
            state_d     = S_WR_WAIT;
          end else begin
            phi_d   = 1'b0;
            state_d = S_PHI1;
          end
        end
      end
      S_WR_WAIT: begin
        hc_en = 1'b0;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          phi_d     = 1'b0;
          state_d   = S_PHI1;
        end
      end
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RST;
      phi_q       <= 1'b0;
      cpu_res_q   <= 1'b0;
      cpu_dbi_q   <= DBI_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      phi_q       <= phi_d;
      cpu_res_q   <= cpu_res_d;
      cpu_dbi_q   <= cpu_dbi_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef CHIP_6502_STEP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q   <= 1'b0;
      released_q <= 1'b0;
    end else begin
      halted_q   <= halted_d;
      released_q <= released_d;
    end
  end
`endif

  assign phi       = phi_q;
  assign cpu_res   = cpu_res_q;
  assign cpu_dbi   = cpu_dbi_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

endmodule
